// File: rtl/vc_wrr_sched.sv
`timescale 1ns/1ps
// vc_wrr_sched: weighted round-robin drain of the four PCIe VC FIFOs onto
// two 5-bit output ports. One arbiter instance per output port. VC0 has
// priority, VC1 is guaranteed a slot after `weight` consecutive VC0 grants,
// and the two source ports within a class take turns.

// Per-port arbiter: request qualification, class/source choice, weight
// counter, RR pointers and the registered output word for one port.
module vc_wrr_port #(
    parameter logic PORT = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            grant_en,
    input  logic            pause,
    input  logic [3:0]      empty,
    input  logic [3:0][4:0] heads,
    input  logic [3:0]      weight,
    output logic [3:0]      gnt,
    output logic [4:0]      out_word,
    output logic            valid
);
    // FIFO index = {source port, vc}: bit0 VC0P0, bit1 VC1P0, bit2 VC0P1, bit3 VC1P1
    logic [3:0] req;
    logic [1:0] r0;        // VC0 requesters, indexed by source port
    logic [1:0] r1;        // VC1 requesters, indexed by source port
    logic [1:0] sel;       // requesters of the chosen class
    logic       pick_vc1;
    logic       src;
    logic       any_req;
    logic [3:0] cnt;       // consecutive VC0 grants while VC1 waited
    logic [1:0] rr;        // next-preferred source, indexed by class
    logic [4:0] gnt_word;

    // A FIFO requests this port when it holds a word routed here and the port is open
    always_comb begin
        req = '0;
        for (int i = 0; i < 4; i++)
            req[i] = grant_en & ~pause & ~empty[i] & (heads[i][4] == PORT);
    end

    assign r0 = {req[2], req[0]};
    assign r1 = {req[3], req[1]};

    // Class choice, then source choice within the class
    always_comb begin
        if (r0 == 2'b00)
            pick_vc1 = 1'b1;
        else if (r1 == 2'b00)
            pick_vc1 = 1'b0;
        else
            pick_vc1 = (weight != 4'd0) && (cnt >= weight);

        sel      = pick_vc1 ? r1 : r0;
        any_req  = |sel;
        // Both sources waiting: the pointer decides; otherwise take whoever asks
        src      = (sel == 2'b11) ? rr[pick_vc1] : sel[1];
        gnt      = '0;
        if (any_req)
            gnt[{src, pick_vc1}] = 1'b1;
        gnt_word = heads[{src, pick_vc1}];
    end

    // Arbitration state only moves on a grant to this port
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            rr  <= '0;
        end else if (any_req) begin
            rr[pick_vc1] <= ~src;
            if (pick_vc1)
                cnt <= '0;
            else if ((r1 != 2'b00) && (cnt != 4'hf))
                cnt <= cnt + 4'd1;
        end
    end

    // Registered output: the granted head word one cycle after its pop
    always_ff @(posedge clk) begin
        if (reset || !any_req) begin
            out_word <= '0;
            valid    <= 1'b0;
        end else begin
            out_word <= gnt_word;
            valid    <= 1'b1;
        end
    end
endmodule

module vc_wrr_sched (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] empty,
    input  logic [4:0] head_VC0P0,
    input  logic [4:0] head_VC1P0,
    input  logic [4:0] head_VC0P1,
    input  logic [4:0] head_VC1P1,
    input  logic [1:0] pause_dest,
    input  logic [3:0] weight,
    output logic [3:0] pop,
    output logic [4:0] out_p0,
    output logic [4:0] out_p1,
    output logic       valid_p0,
    output logic       valid_p1
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t          state_q;
    state_t          state_d;
    logic            grant_en;
    logic [3:0][4:0] heads;
    logic [1:0][3:0] gnt;
    logic [1:0][4:0] out_w;
    logic [1:0]      vld;

    assign heads = {head_VC1P1, head_VC0P1, head_VC1P0, head_VC0P0};

    // Control state register
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state: follow enable, one cycle behind
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable)  state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grants need RUN and a live enable; reset kills pops in the same cycle
    always_comb begin
        grant_en = (state_q == RUN) && enable && !reset;
    end

    // Each FIFO targets one port, so the two arbiters never grant the same FIFO
    for (genvar k = 0; k < 2; k++) begin : g_port
        vc_wrr_port #(.PORT(k == 1)) u_port (
            .clk      (clk),
            .reset    (reset),
            .grant_en (grant_en),
            .pause    (pause_dest[k]),
            .empty    (empty),
            .heads    (heads),
            .weight   (weight),
            .gnt      (gnt[k]),
            .out_word (out_w[k]),
            .valid    (vld[k])
        );
    end

    assign pop      = gnt[0] | gnt[1];
    assign out_p0   = out_w[0];
    assign out_p1   = out_w[1];
    assign valid_p0 = vld[0];
    assign valid_p1 = vld[1];
endmodule

// File: tb/tb_vc_wrr_sched.sv
`timescale 1ns/1ps
// Bench for vc_wrr_sched: FIFOs modelled as queues, grants predicted by a
// rule-level reference model, directed scenarios followed by random traffic.
module tb_vc_wrr_sched;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] empty;
    logic [4:0] h [4];
    logic [1:0] pause_dest;
    logic [3:0] weight;
    logic [3:0] pop;
    logic [4:0] out_p0, out_p1;
    logic       valid_p0, valid_p1;

    always #5 clk = ~clk;

    vc_wrr_sched dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .empty      (empty),
        .head_VC0P0 (h[0]),
        .head_VC1P0 (h[1]),
        .head_VC0P1 (h[2]),
        .head_VC1P1 (h[3]),
        .pause_dest (pause_dest),
        .weight     (weight),
        .pop        (pop),
        .out_p0     (out_p0),
        .out_p1     (out_p1),
        .valid_p0   (valid_p0),
        .valid_p1   (valid_p1)
    );

    int checks   = 0;
    int failures = 0;

    // FIFO contents; index = 2*source_port + vc
    logic [4:0] q [4][$];

    // Reference model state
    int         m_cnt [2];
    bit         m_rr  [2][2];
    bit         m_run;
    logic [4:0] e_out [2];
    bit         e_vld [2];
    bit         out_known = 1'b0;

    // DUT values captured each cycle
    logic [3:0] c_pop;
    logic [4:0] c_out0, c_out1;
    logic       c_v0, c_v1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check last cycle's outputs, drive inputs, check pop, advance model
    task automatic cycle(input bit rst, input bit en, input logic [1:0] pz, input logic [3:0] w);
        logic [3:0] mp;
        logic [4:0] nout [2];
        bit         nv [2];
        @(negedge clk);
        c_out0 = out_p0; c_out1 = out_p1; c_v0 = valid_p0; c_v1 = valid_p1;
        if (out_known) begin
            chk("out_p0",   c_out0, e_out[0]);
            chk("out_p1",   c_out1, e_out[1]);
            chk("valid_p0", c_v0,   e_vld[0]);
            chk("valid_p1", c_v1,   e_vld[1]);
        end
        reset = rst; enable = en; pause_dest = pz; weight = w;
        for (int i = 0; i < 4; i++) begin
            empty[i] = (q[i].size() == 0);
            h[i]     = empty[i] ? 5'($urandom) : q[i][0];
        end
        #1;
        c_pop = pop;
        mp = '0;
        for (int k = 0; k < 2; k++) begin
            bit rq [4];
            int n0, n1, cls, src, f;
            nout[k] = '0;
            nv[k]   = 1'b0;
            for (int i = 0; i < 4; i++)
                rq[i] = !empty[i] && (h[i][4] == k) && en && !rst && !pz[k] && m_run;
            n0 = int'(rq[0]) + int'(rq[2]);
            n1 = int'(rq[1]) + int'(rq[3]);
            if (n0 + n1 > 0) begin
                if (n0 == 0)      cls = 1;
                else if (n1 == 0) cls = 0;
                else              cls = (w != 0 && m_cnt[k] >= int'(w)) ? 1 : 0;
                if (rq[cls] && rq[cls + 2]) src = int'(m_rr[k][cls]);
                else                        src = rq[cls + 2] ? 1 : 0;
                f = 2 * src + cls;
                mp[f]   = 1'b1;
                nout[k] = h[f];
                nv[k]   = 1'b1;
                m_rr[k][cls] = (src == 0);
                if (cls == 1)                     m_cnt[k] = 0;
                else if (n1 > 0 && m_cnt[k] < 15) m_cnt[k]++;
            end
        end
        chk("pop", c_pop, mp);
        for (int i = 0; i < 4; i++)
            if (mp[i]) void'(q[i].pop_front());
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_cnt[k] = 0; m_rr[k][0] = 0; m_rr[k][1] = 0;
                e_out[k] = '0; e_vld[k] = 0;
            end
            m_run     = 0;
            out_known = 1'b1;
        end else begin
            m_run = en;
            for (int k = 0; k < 2; k++) begin
                e_out[k] = nout[k];
                e_vld[k] = nv[k];
            end
        end
    endtask

    // Empty FIFOs, reset, then one enabled cycle so the FSM sits in RUN
    task automatic do_reset();
        for (int i = 0; i < 4; i++) q[i].delete();
        cycle(1, 1, 2'b00, 4'd0);
        cycle(1, 1, 2'b00, 4'd0);
        cycle(0, 1, 2'b00, 4'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int alt  [4];
        int wseq [6];
        reset = 1'b1; enable = 1'b0; empty = 4'hf; pause_dest = 2'b00; weight = 4'd0;
        for (int i = 0; i < 4; i++) h[i] = '0;
        m_run = 0;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_rr[k][0] = 0; m_rr[k][1] = 0; e_out[k] = '0; e_vld[k] = 0;
        end

        // Reset held 3 cycles with all FIFOs loaded
        for (int j = 0; j < 3; j++) begin
            q[0].push_back(5'h03); q[1].push_back(5'h04);
            q[2].push_back(5'h13); q[3].push_back(5'h15);
        end
        for (int j = 0; j < 3; j++) begin
            cycle(1, 1, 2'b00, 4'd0);
            chk("rst_pop", c_pop, 4'b0000);
        end
        cycle(0, 1, 2'b00, 4'd0);
        chk("rst_out", {c_out1, c_out0}, 10'd0);
        chk("rst_vld", {c_v1, c_v0}, 2'b00);
        chk("idle_pop", c_pop, 4'b0000);
        cycle(0, 1, 2'b00, 4'd0);
        chk("first_pop", c_pop, 4'b0101);

        // Same-class alternation between source ports
        do_reset();
        for (int j = 0; j < 4; j++) begin q[0].push_back(5'h03); q[2].push_back(5'h03); end
        alt = '{1, 4, 1, 4};
        for (int j = 0; j < 4; j++) begin
            cycle(0, 1, 2'b00, 4'd0);
            chk("alt_pop", c_pop, alt[j]);
            if (j > 0) chk("alt_out", {c_v0, c_out0}, {1'b1, 5'h03});
        end

        // weight=2: VC0, VC0, VC1 repeating
        do_reset();
        for (int j = 0; j < 6; j++) begin q[0].push_back(5'h01); q[1].push_back(5'h02); end
        wseq = '{1, 1, 2, 1, 1, 2};
        for (int j = 0; j < 6; j++) begin
            cycle(0, 1, 2'b00, 4'd2);
            chk("wgt_pop", c_pop, wseq[j]);
        end

        // Counter saturates at 15 under strict priority, then weight=15 lets VC1 in
        do_reset();
        for (int j = 0; j < 20; j++) begin q[0].push_back(5'h01); q[1].push_back(5'h02); end
        for (int j = 0; j < 17; j++) cycle(0, 1, 2'b00, 4'd0);
        chk("strict_pop", c_pop, 4'b0001);
        cycle(0, 1, 2'b00, 4'd15);
        chk("sat_pop", c_pop, 4'b0010);

        // Both ports granted in the same cycle
        do_reset();
        q[0].push_back(5'h03); q[3].push_back(5'h15);
        cycle(0, 1, 2'b00, 4'd0);
        chk("dual_pop", c_pop, 4'b1001);
        cycle(0, 1, 2'b00, 4'd0);
        chk("dual_out", {c_v1, c_out1, c_v0, c_out0}, {1'b1, 5'h15, 1'b1, 5'h03});

        // Pause port 0, port 1 keeps flowing; port 0 resumes with its pointer
        do_reset();
        for (int j = 0; j < 8; j++) begin
            q[0].push_back(5'h07); q[2].push_back(5'h07); q[3].push_back(5'h1a);
        end
        cycle(0, 1, 2'b00, 4'd0);
        chk("pre_pause_pop", c_pop, 4'b1001);
        for (int j = 0; j < 3; j++) begin
            cycle(0, 1, 2'b01, 4'd0);
            chk("pause_pop", c_pop, 4'b1000);
        end
        cycle(0, 1, 2'b00, 4'd0);
        chk("resume_pop", c_pop, 4'b1100);

        // Enable drop mid-stream
        cycle(0, 1, 2'b00, 4'd0);
        chk("en_pop", c_pop, 4'b1001);
        cycle(0, 0, 2'b00, 4'd0);
        chk("endrop_pop", c_pop, 4'b0000);
        chk("endrop_vld", {c_v1, c_v0}, 2'b11);
        cycle(0, 0, 2'b00, 4'd0);
        chk("endrop_vld2", {c_v1, c_v0}, 2'b00);
        cycle(0, 1, 2'b00, 4'd0);
        chk("reen_idle_pop", c_pop, 4'b0000);
        cycle(0, 1, 2'b00, 4'd0);
        chk("reen_pop", c_pop, 4'b1100);

        // Random traffic with occasional reset, enable drops, pause and weight changes
        for (int n = 0; n < 400; n++) begin
            bit         rst, en;
            logic [1:0] pz;
            logic [3:0] w;
            for (int i = 0; i < 4; i++)
                if (q[i].size() < 4 && $urandom_range(0, 2) != 0) q[i].push_back(5'($urandom));
            rst = ($urandom_range(0, 49) == 0);
            en  = ($urandom_range(0, 9) != 0);
            pz  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            w   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 4));
            cycle(rst, en, pz, w);
        end
        cycle(0, 0, 2'b00, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
